// File: rtl/mem_port_arbiter_pkg.sv
// Shared widths and FSM encoding for the memory port arbiter and its PCI write buffer.
package mem_port_arbiter_pkg;

  localparam int ADDR_W = 21;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_pci_wr_buffer.sv
// One-entry holding buffer for host write strobes; drops a strobe that finds it full.
module pci_wr_buffer
  import mem_port_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              grant,
  output logic              valid,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              overflow
);

  logic load;

  // A grant frees the slot in the same cycle, so a back-to-back strobe still fits.
  assign load = wr_en && (!valid || grant);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (load) begin
        valid <= 1'b1;
      end else if (grant) begin
        valid <= 1'b0;
      end
      if (wr_en && !load) begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      addr <= wr_addr;
      data <= wr_data;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: flag writes, buffered host writes and user accesses,
// with a starvation override that eventually forces the user through.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pci_wr_en,
  input  logic [ADDR_W-1:0] pci_req_addr,
  input  logic [DATA_W-1:0] pci_input_data,
  output logic              pci_overflow,
  input  logic              flag_we,
  input  logic [ADDR_W-1:0] flag_addr,
  input  logic [DATA_W-1:0] flag_data,
  output logic              flag_gnt,
  input  logic              usr_req,
  input  logic              usr_we,
  input  logic [ADDR_W-1:0] usr_addr,
  input  logic [DATA_W-1:0] usr_wdata,
  output logic              usr_gnt,
  output logic [DATA_W-1:0] usr_rdata,
  output logic              usr_rvalid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  arb_state_t        state, state_next;
  logic [CNT_W-1:0]  starve_cnt;
  logic              win_flag, win_pci, win_usr;
  logic              pbuf_valid;
  logic [ADDR_W-1:0] pbuf_addr;
  logic [DATA_W-1:0] pbuf_data;

  pci_wr_buffer u_pci_wr_buffer (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (pci_wr_en),
    .wr_addr  (pci_req_addr),
    .wr_data  (pci_input_data),
    .grant    (win_pci),
    .valid    (pbuf_valid),
    .addr     (pbuf_addr),
    .data     (pbuf_data),
    .overflow (pci_overflow)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    win_flag   = 1'b0;
    win_pci    = 1'b0;
    win_usr    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (usr_req && starve_cnt == CNT_MAX) begin
          win_usr = 1'b1;
        end else if (flag_we) begin
          win_flag = 1'b1;
        end else if (pbuf_valid) begin
          win_pci = 1'b1;
        end else if (usr_req) begin
          win_usr = 1'b1;
        end
        if (win_flag || win_pci || (win_usr && usr_we)) begin
          state_next = ST_WR;
        end else if (win_usr) begin
          state_next = ST_RD;
        end
      end
      ST_WR: state_next = ST_IDLE;
      ST_RD: begin
        if (mem_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Request strobes follow the state directly, so they drop with the asynchronous reset.
  assign mem_req = (state == ST_WR) || (state == ST_RD);
  assign mem_we  = (state == ST_WR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_gnt   <= 1'b0;
      usr_gnt    <= 1'b0;
      usr_rvalid <= 1'b0;
      usr_rdata  <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      starve_cnt <= '0;
    end else begin
      flag_gnt   <= win_flag;
      usr_gnt    <= win_usr;
      usr_rvalid <= (state == ST_RD) && mem_ready;
      if ((state == ST_RD) && mem_ready) begin
        usr_rdata <= mem_rdata;
      end
      if (win_flag) begin
        mem_addr  <= flag_addr;
        mem_wdata <= flag_data;
      end else if (win_pci) begin
        mem_addr  <= pbuf_addr;
        mem_wdata <= pbuf_data;
      end else if (win_usr) begin
        mem_addr  <= usr_addr;
        mem_wdata <= usr_wdata;
      end
      if (!usr_req || win_usr) begin
        starve_cnt <= '0;
      end else if ((win_flag || win_pci) && starve_cnt != CNT_MAX) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: single-transaction vector table plus
// priority, overflow, starvation and reset-during-read sequences.
module tb_mem_port_arbiter;

  localparam logic [1:0] K_PCI  = 2'd0;
  localparam logic [1:0] K_FLAG = 2'd1;
  localparam logic [1:0] K_UWR  = 2'd2;
  localparam logic [1:0] K_URD  = 2'd3;

  typedef struct {
    logic [1:0]  kind;
    logic [20:0] addr;
    logic [31:0] data;
    int          delay;
    logic [31:0] rdata;
    int          lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pci_wr_en = 1'b0;
  logic [20:0] pci_req_addr = '0;
  logic [31:0] pci_input_data = '0;
  logic        pci_overflow;
  logic        flag_we = 1'b0;
  logic [20:0] flag_addr = '0;
  logic [31:0] flag_data = '0;
  logic        flag_gnt;
  logic        usr_req = 1'b0;
  logic        usr_we = 1'b0;
  logic [20:0] usr_addr = '0;
  logic [31:0] usr_wdata = '0;
  logic        usr_gnt;
  logic [31:0] usr_rdata;
  logic        usr_rvalid;
  logic        mem_req;
  logic        mem_we;
  logic [20:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;

  int passed = 0;
  int total = 0;

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pci_wr_en      (pci_wr_en),
    .pci_req_addr   (pci_req_addr),
    .pci_input_data (pci_input_data),
    .pci_overflow   (pci_overflow),
    .flag_we        (flag_we),
    .flag_addr      (flag_addr),
    .flag_data      (flag_data),
    .flag_gnt       (flag_gnt),
    .usr_req        (usr_req),
    .usr_we         (usr_we),
    .usr_addr       (usr_addr),
    .usr_wdata      (usr_wdata),
    .usr_gnt        (usr_gnt),
    .usr_rdata      (usr_rdata),
    .usr_rvalid     (usr_rvalid),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_ready      (mem_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".mem_req"},    {31'd0, mem_req},      32'd0);
    chk({tag, ".mem_we"},     {31'd0, mem_we},       32'd0);
    chk({tag, ".flag_gnt"},   {31'd0, flag_gnt},     32'd0);
    chk({tag, ".usr_gnt"},    {31'd0, usr_gnt},      32'd0);
    chk({tag, ".usr_rvalid"}, {31'd0, usr_rvalid},   32'd0);
    chk({tag, ".overflow"},   {31'd0, pci_overflow}, 32'd0);
    chk({tag, ".mem_addr"},   {11'd0, mem_addr},     32'd0);
    chk({tag, ".mem_wdata"},  mem_wdata,             32'd0);
    chk({tag, ".usr_rdata"},  usr_rdata,             32'd0);
  endtask

  initial begin
    vec_t vecs[5];
    vec_t t;
    int lat;
    int nflag;
    int seen_rvalid;
    bit got_usr;

    vecs[0] = '{kind: K_PCI,  addr: 21'h00010, data: 32'hDEADBEEF, delay: 0, rdata: 32'h0,        lat: 2};
    vecs[1] = '{kind: K_FLAG, addr: 21'h7FFFE, data: 32'h00000004, delay: 0, rdata: 32'h0,        lat: 1};
    vecs[2] = '{kind: K_UWR,  addr: 21'h12345, data: 32'hA5A5A5A5, delay: 0, rdata: 32'h0,        lat: 1};
    vecs[3] = '{kind: K_URD,  addr: 21'h00ABC, data: 32'h0,        delay: 2, rdata: 32'h12345678, lat: 1};
    vecs[4] = '{kind: K_URD,  addr: 21'h1FFFF, data: 32'h0,        delay: 0, rdata: 32'hCAFEF00D, lat: 1};

    #1;
    chk_all_zero("reset");
    step();
    rst_n = 1'b1;
    step();

    for (int v = 0; v < 5; v++) begin
      t = vecs[v];
      case (t.kind)
        K_PCI:  begin pci_wr_en = 1'b1; pci_req_addr = t.addr; pci_input_data = t.data; end
        K_FLAG: begin flag_we = 1'b1; flag_addr = t.addr; flag_data = t.data; end
        K_UWR:  begin usr_req = 1'b1; usr_we = 1'b1; usr_addr = t.addr; usr_wdata = t.data; end
        default: begin usr_req = 1'b1; usr_we = 1'b0; usr_addr = t.addr; usr_wdata = 32'h0; end
      endcase
      lat = 0;
      while (!mem_req && lat < 10) begin
        step();
        lat++;
        pci_wr_en = 1'b0;
      end
      chk($sformatf("vec%0d.latency", v), lat, t.lat);
      chk($sformatf("vec%0d.mem_we", v), {31'd0, mem_we}, {31'd0, t.kind != K_URD});
      chk($sformatf("vec%0d.mem_addr", v), {11'd0, mem_addr}, {11'd0, t.addr});
      chk($sformatf("vec%0d.flag_gnt", v), {31'd0, flag_gnt}, {31'd0, t.kind == K_FLAG});
      chk($sformatf("vec%0d.usr_gnt", v), {31'd0, usr_gnt}, {31'd0, t.kind == K_UWR || t.kind == K_URD});
      flag_we = 1'b0;
      usr_req = 1'b0;
      if (t.kind == K_URD) begin
        repeat (t.delay) step();
        chk($sformatf("vec%0d.rd_hold", v), {31'd0, mem_req}, 32'd1);
        mem_ready = 1'b1;
        mem_rdata = t.rdata;
        step();
        mem_ready = 1'b0;
        chk($sformatf("vec%0d.rvalid", v), {31'd0, usr_rvalid}, 32'd1);
        chk($sformatf("vec%0d.rdata", v), usr_rdata, t.rdata);
        chk($sformatf("vec%0d.rd_done", v), {31'd0, mem_req}, 32'd0);
        step();
        chk($sformatf("vec%0d.rvalid_pulse", v), {31'd0, usr_rvalid}, 32'd0);
      end else begin
        chk($sformatf("vec%0d.mem_wdata", v), mem_wdata, t.data);
        step();
        chk($sformatf("vec%0d.wr_one_cycle", v), {31'd0, mem_req}, 32'd0);
        step();
      end
    end

    // Flag and user read raised together: flag first, then the read.
    flag_we = 1'b1; flag_addr = 21'h7FFFE; flag_data = 32'h4;
    usr_req = 1'b1; usr_we = 1'b0; usr_addr = 21'h00100;
    step();
    chk("prio.flag_gnt", {31'd0, flag_gnt}, 32'd1);
    chk("prio.usr_gnt_low", {31'd0, usr_gnt}, 32'd0);
    chk("prio.flag_addr", {11'd0, mem_addr}, 32'h7FFFE);
    flag_we = 1'b0;
    step();
    chk("prio.gap", {31'd0, mem_req}, 32'd0);
    step();
    chk("prio.usr_gnt", {31'd0, usr_gnt}, 32'd1);
    chk("prio.usr_read", {31'd0, mem_req && !mem_we}, 32'd1);
    chk("prio.usr_addr", {11'd0, mem_addr}, 32'h00100);
    usr_req = 1'b0;
    mem_ready = 1'b1; mem_rdata = 32'h12345678;
    step();
    mem_ready = 1'b0;
    chk("prio.rvalid", {31'd0, usr_rvalid}, 32'd1);
    chk("prio.rdata", usr_rdata, 32'h12345678);
    step();

    // Starvation: flag_we held high, user forced in after four flag grants.
    flag_we = 1'b1; flag_addr = 21'h00055; flag_data = 32'h66;
    usr_req = 1'b1; usr_we = 1'b0; usr_addr = 21'h00400;
    nflag = 0;
    got_usr = 1'b0;
    for (int i = 0; i < 40 && !got_usr; i++) begin
      step();
      if (flag_gnt) nflag++;
      if (usr_gnt) got_usr = 1'b1;
    end
    chk("starve.usr_gnt_seen", {31'd0, got_usr}, 32'd1);
    chk("starve.flag_grants_before", nflag, 4);
    chk("starve.usr_addr", {11'd0, mem_addr}, 32'h00400);
    usr_req = 1'b0;
    flag_we = 1'b0;
    mem_ready = 1'b1; mem_rdata = 32'h0BADF00D;
    step();
    mem_ready = 1'b0;
    chk("starve.rdata", usr_rdata, 32'h0BADF00D);
    step();

    // Overflow: two host strobes during a five-cycle user read.
    usr_req = 1'b1; usr_we = 1'b0; usr_addr = 21'h00200;
    step();
    chk("ovf.usr_gnt", {31'd0, usr_gnt}, 32'd1);
    usr_req = 1'b0;
    pci_wr_en = 1'b1; pci_req_addr = 21'h00300; pci_input_data = 32'h11111111;
    step();
    pci_req_addr = 21'h00301; pci_input_data = 32'h22222222;
    step();
    pci_wr_en = 1'b0;
    chk("ovf.flag_set", {31'd0, pci_overflow}, 32'd1);
    step();
    step();
    chk("ovf.rd_still_pending", {31'd0, mem_req}, 32'd1);
    mem_ready = 1'b1; mem_rdata = 32'h55AA55AA;
    step();
    mem_ready = 1'b0;
    chk("ovf.rvalid", {31'd0, usr_rvalid}, 32'd1);
    step();
    chk("ovf.pci_write", {31'd0, mem_req && mem_we}, 32'd1);
    chk("ovf.pci_addr", {11'd0, mem_addr}, 32'h00300);
    chk("ovf.pci_data", mem_wdata, 32'h11111111);
    step();
    chk("ovf.no_second_write", {31'd0, mem_req}, 32'd0);
    step();
    chk("ovf.sticky", {31'd0, pci_overflow}, 32'd1);

    // Reset asserted mid-read.
    usr_req = 1'b1; usr_we = 1'b0; usr_addr = 21'h00777;
    step();
    usr_req = 1'b0;
    step();
    chk("rst.in_read", {31'd0, mem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_rd");
    mem_ready = 1'b1; mem_rdata = 32'hFFFFFFFF;
    step();
    rst_n = 1'b1;
    seen_rvalid = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (usr_rvalid || mem_req) seen_rvalid++;
    end
    mem_ready = 1'b0;
    chk("rst.no_rvalid_after", seen_rvalid, 0);
    chk("rst.rdata_cleared", usr_rdata, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
